// File: rtl/fft16_stage_sequencer.sv
// Iterative 16-point radix-2 DIT stage sequencer for an 8-butterfly combinational array.
// Latency: load accepted at E0, stages 0..3 written at E1..E4, done pulse in the cycle after E4.
// Backpressure: none; load is accepted in IDLE/DONE only and ignored while stages run.
//
// Ports:
//   clk, n_rst      rising-edge clock, asynchronous active-low reset
//   load            start pulse, samples_in valid in the same cycle
//   samples_in      16 complex samples, natural order, word 2k = re, 2k+1 = im
//   bfly_in         operand bundle, slot j = words 6j..6j+5 {top re, top im, bot re, bot im, tw re, tw im}
//   bfly_out        array results, slot j = words 4j..4j+3 {top' re, top' im, bot' re, bot' im}
//   busy            high while stages execute
//   done            one-cycle completion pulse
//   result          buffer contents in natural frequency order

module fft16_stage_sequencer #(
   parameter int WIDTH = 16   // fixed by the butterfly array; only 16 is supported
) (
   input  logic                   clk,
   input  logic                   n_rst,
   input  logic                   load,
   input  logic [31:0][WIDTH-1:0] samples_in,
   output logic [47:0][WIDTH-1:0] bfly_in,
   input  logic [31:0][WIDTH-1:0] bfly_out,
   output logic                   busy,
   output logic                   done,
   output logic [31:0][WIDTH-1:0] result
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             accept;
   logic [1:0]       stage;
   logic [WIDTH-1:0] x_re [16];
   logic [WIDTH-1:0] x_im [16];
   logic [3:0]       top_idx [8];
   logic [3:0]       bot_idx [8];
   logic [2:0]       tw_idx  [8];

   function automatic logic [3:0] bitrev4(input logic [3:0] k);
      return {k[0], k[1], k[2], k[3]};
   endfunction

   // top = (j >> s) * 2h + (j & (h-1)); the shift amount is widened so that
   // s = 3 does not wrap the (s + 1) term back to zero.
   function automatic logic [3:0] top_of(input logic [2:0] j, input logic [1:0] s);
      logic [3:0] h;
      logic [3:0] p;
      h = 4'd1 << s;
      p = {1'b0, j} & (h - 4'd1);
      return (({1'b0, j} >> s) << (3'(s) + 3'd1)) | p;
   endfunction

   // top always has bit s clear, so adding h is a plain OR
   function automatic logic [3:0] bot_of(input logic [2:0] j, input logic [1:0] s);
      return top_of(j, s) | (4'd1 << s);
   endfunction

   // p < 2^s, so p << (3 - s) always fits in three bits
   function automatic logic [2:0] tw_of(input logic [2:0] j, input logic [1:0] s);
      logic [3:0] p;
      p = {1'b0, j} & ((4'd1 << s) - 4'd1);
      return 3'(p << (2'd3 - s));
   endfunction

   // W16^t = cos(2*pi*t/16) - j*sin(2*pi*t/16), Q1.15
   function automatic logic [WIDTH-1:0] tw_re(input logic [2:0] t);
      case (t)
         3'd0:    return WIDTH'(16'h7FFF);
         3'd1:    return WIDTH'(16'h7642);
         3'd2:    return WIDTH'(16'h5A82);
         3'd3:    return WIDTH'(16'h30FC);
         3'd4:    return WIDTH'(16'h0000);
         3'd5:    return WIDTH'(16'hCF04);
         3'd6:    return WIDTH'(16'hA57E);
         default: return WIDTH'(16'h89BE);
      endcase
   endfunction

   function automatic logic [WIDTH-1:0] tw_im(input logic [2:0] t);
      case (t)
         3'd0:    return WIDTH'(16'h0000);
         3'd1:    return WIDTH'(16'hCF04);
         3'd2:    return WIDTH'(16'hA57E);
         3'd3:    return WIDTH'(16'h89BE);
         3'd4:    return WIDTH'(16'h8001);
         3'd5:    return WIDTH'(16'h89BE);
         3'd6:    return WIDTH'(16'hA57E);
         default: return WIDTH'(16'hCF04);
      endcase
   endfunction

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      case (state)
         S_IDLE: begin
            if (load) begin
               accept    = 1'b1;
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if (stage == 2'd3) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            done = 1'b1;
            // a load here restarts immediately, giving back-to-back transforms
            if (load) begin
               accept    = 1'b1;
               state_nxt = S_RUN;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------- pairing
   always_comb begin
      for (int j = 0; j < 8; j++) begin
         top_idx[j] = top_of(3'(j), stage);
         bot_idx[j] = bot_of(3'(j), stage);
         tw_idx[j]  = tw_of(3'(j), stage);
      end
   end

   // Operand bundle is a pure function of X and stage, valid in every state.
   always_comb begin
      bfly_in = '0;
      for (int j = 0; j < 8; j++) begin
         bfly_in[6*j+0] = x_re[top_idx[j]];
         bfly_in[6*j+1] = x_im[top_idx[j]];
         bfly_in[6*j+2] = x_re[bot_idx[j]];
         bfly_in[6*j+3] = x_im[bot_idx[j]];
         bfly_in[6*j+4] = tw_re(tw_idx[j]);
         bfly_in[6*j+5] = tw_im(tw_idx[j]);
      end
   end

   // ---------------------------------------------------------------- buffer
   // Each stage writes every index exactly once (8 tops + 8 bottoms), so the
   // per-slot write-back never collides.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         stage <= 2'd0;
         for (int i = 0; i < 16; i++) begin
            x_re[i] <= '0;
            x_im[i] <= '0;
         end
      end else if (accept) begin
         stage <= 2'd0;
         for (int k = 0; k < 16; k++) begin
            x_re[bitrev4(4'(k))] <= samples_in[2*k];
            x_im[bitrev4(4'(k))] <= samples_in[2*k+1];
         end
      end else if (state == S_RUN) begin
         stage <= stage + 2'd1;
         for (int j = 0; j < 8; j++) begin
            x_re[top_idx[j]] <= bfly_out[4*j+0];
            x_im[top_idx[j]] <= bfly_out[4*j+1];
            x_re[bot_idx[j]] <= bfly_out[4*j+2];
            x_im[bot_idx[j]] <= bfly_out[4*j+3];
         end
      end
   end

   always_comb begin
      result = '0;
      for (int i = 0; i < 16; i++) begin
         result[2*i]   = x_re[i];
         result[2*i+1] = x_im[i];
      end
   end

endmodule

// File: doc/fft16_stage_sequencer.md
# fft16_stage_sequencer

Iterative controller that drives the 8-butterfly parallel array: it owns the 16-point complex sample register buffer, builds the 48-word operand bundle (8 × {top re, top im, bottom re, bottom im, twiddle re, twiddle im}) for each radix-2 DIT stage, and writes the array's 32-word result bundle back into the buffer. It runs four stages per transform and sits between the sample source and the butterfly array. The butterfly array is purely combinational, so each stage completes in one clock.

## Interface
- WIDTH, 16, word width; fixed by the butterfly array, other values unsupported.
- clk  in  1  rising-edge clock.
- n_rst  in  1  asynchronous active-low reset.
- load  in  1  start pulse; `samples_in` is valid in the same cycle.
- samples_in  in  [31:0][WIDTH-1:0]  16 complex samples in natural order; word 2k is real, word 2k+1 is imaginary; signed Q1.15.
- bfly_in  out  [47:0][WIDTH-1:0]  operand bundle to the array; slot j occupies words 6j..6j+5.
- bfly_out  in  [31:0][WIDTH-1:0]  array results; slot j occupies words 4j..4j+3 as {top' re, top' im, bottom' re, bottom' im}.
- busy  out  1  high while stages execute.
- done  out  1  one-cycle pulse when the transform completes.
- result  out  [31:0][WIDTH-1:0]  buffer contents in natural frequency order, with the same word layout as `samples_in`.

## Operation
- Buffer X[0..15] holds complex registers. `result` is driven directly from X.
- FSM states:
  - IDLE: `load` causes X[bitrev4(k)] <= sample k, stage <= 0, and a move to RUN.
  - RUN: each cycle, X is written back from `bfly_out` and stage increments. After stage 3 is written, the FSM moves to DONE.
  - DONE: `done` = 1 for one cycle, then the FSM returns to IDLE. A `load` in DONE is accepted exactly as in IDLE.
- `load` in RUN is ignored.
- Pairing for stage s (h = 2^s), slot j = 0..7:
  - p = j & (h-1).
  - top = (j >> s)·2h + p.
  - bottom = top + h.
  - Twiddle index t = p << (3-s).
- Twiddle ROM holds W16^t = {cos, −sin}(2πt/16) in Q1.15 {re, im}:
  - t0 7FFF,0000; t1 7642,CF04; t2 5A82,A57E; t3 30FC,89BE.
  - t4 0000,8001; t5 CF04,89BE; t6 A57E,A57E; t7 89BE,CF04.
- `bfly_in` is a combinational function of X and stage in every state.
- Write-back: X[top] <= slot j words 0,1; X[bottom] <= slot j words 2,3. Each stage touches every index exactly once, so there are no write conflicts.
- No arithmetic happens in this block. Scaling and saturation belong to the butterfly array.

## Timing
- Reset values:
  - FSM = IDLE, stage = 0, X = 0.
  - busy = 0, done = 0, result = all zero.
  - `bfly_in` has every twiddle pair = 7FFF,0000 and all other words = 0.
- Latency:
  - Rising edge E0 samples `load`.
  - Edges E1..E4 perform stages 0..3.
  - `busy` is high from after E0 until after E4, exactly 4 cycles.
  - `done` is high for the cycle after E4.
  - `result` holds the final value from E4 until the next accepted `load`.
- Stage s operands are present on `bfly_in` during the cycle ending at edge E(s+1).
- Back-to-back: a `load` during the `done` cycle starts a new transform with no bubble, and `done` still deasserts.
- Reset mid-operation: an immediate return to reset values, with no `done` pulse.

## Test plan
- Reset: assert `n_rst` = 0 mid-RUN. Required: busy = 0, done = 0, result = 0, slot 3 twiddle = 7FFF,0000, and no `done` after release.
- Permutation check: stub the array as identity (`bfly_out` slot j = `bfly_in` words 6j..6j+3). Load sample k = {k+1, 0}. Required after `done`: result real word i = bitrev4(i)+1, all imaginary words = 0.
- Twiddle and pairing check:
  - Stage 0: slot 5 pairs X10/X11 with twiddle 7FFF,0000.
  - Stage 2: slot 5 pairs X9/X13 with twiddle 5A82,A57E.
  - Stage 3: slot 4 pairs X4/X12 with twiddle 0000,8001; slot 7 pairs X7/X15 with twiddle 89BE,CF04.
- Latency: pulse `load` at E0. Required: `busy` high for exactly 4 cycles, `done` high only after E4.
- Hold `load` high for 8 cycles. Required: the second transform starts in the `done` cycle (busy reasserts after E5), `done` pulses again after E9, and `load` during RUN has no effect.
- Golden model: connect the real butterfly array. Load the impulse sample0 = {4000,0000}. Required: all 16 result bins equal the bit-accurate software model of the same butterfly scaling.
